// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings, flag bit positions,
// default datapath geometry and the per-opcode flag-update rules.
package alu_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_LANE  = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;

    typedef enum logic [3:0] {
        OP_ADD      = 4'b0000,
        OP_SUB      = 4'b0001,
        OP_XOR      = 4'b0010,
        OP_RED      = 4'b0011,
        OP_SLL      = 4'b0100,
        OP_SRA      = 4'b0101,
        OP_ROR      = 4'b0110,
        OP_PADDSB   = 4'b0111,
        OP_LW       = 4'b1000,
        OP_SW       = 4'b1001,
        OP_LHB      = 4'b1010,
        OP_LLB      = 4'b1011,
        OP_LLB_ALT0 = 4'b1100,
        OP_LLB_ALT1 = 4'b1101,
        OP_PCS      = 4'b1110,
        OP_MUL      = 4'b1111
    } opcode_e;

    typedef enum logic {
        MS_IDLE,
        MS_RUN
    } mul_state_e;

    function automatic logic updates_z(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_SLL,
            OP_SRA, OP_ROR, OP_PADDSB, OP_MUL: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic updates_nv(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operation/result handshake bundle between a requester (master) and the ALU (slave).
interface alu_pipe_if #(
    parameter int WIDTH = alu_pkg::DEF_WIDTH
);
    logic             in_vld;
    logic             in_rdy;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] input_A;
    logic [WIDTH-1:0] input_B;
    logic             flush;
    logic             out_vld;
    logic             out_rdy;
    logic [WIDTH-1:0] out;
    logic [2:0]       flag;
    logic             busy;

    modport master (
        output in_vld, opcode, input_A, input_B, flush, out_rdy,
        input  in_rdy, out_vld, out, flag, busy
    );

    modport slave (
        input  in_vld, opcode, input_A, input_B, flush, out_rdy,
        output in_rdy, out_vld, out, flag, busy
    );
endinterface

// File: rtl/alu_core.sv
// Combinational single-cycle datapath: every opcode except MUL produces its
// result here; the signed-overflow indication is valid for ADD/SUB only.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANE  = DEF_LANE
) (
    input  logic [3:0]       opcode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o
);
    localparam int SHW    = $clog2(WIDTH);
    localparam int NBYTES = WIDTH / 8;
    localparam int NLANES = WIDTH / LANE;

    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   sum, diff, sll_res, sra_res, ror_res, red_res, padd_res;
    logic [WIDTH-1:0]   lw_res, lhb_res, llb_res;
    logic [2*WIDTH-1:0] rot_wide;
    logic               add_ovf, sub_ovf;

    assign shamt    = b_i[SHW-1:0];
    assign sum      = a_i + b_i;
    assign diff     = a_i - b_i;
    assign add_ovf  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    assign sub_ovf  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
    assign sll_res  = a_i << shamt;
    assign sra_res  = $signed(a_i) >>> shamt;
    // Rotating a doubled copy makes amount 0 fall out naturally as A.
    assign rot_wide = {a_i, a_i} >> shamt;
    assign ror_res  = rot_wide[WIDTH-1:0];
    assign lw_res   = (a_i & ~WIDTH'(1)) + (b_i << 1);
    assign lhb_res  = (a_i & ({WIDTH{1'b1}} >> 8)) | (WIDTH'(b_i[7:0]) << (WIDTH - 8));
    assign llb_res  = (a_i & ~WIDTH'(8'hFF)) | WIDTH'(b_i[7:0]);

    always_comb begin
        red_res = '0;
        for (int i = 0; i < NBYTES; i++) begin
            red_res = red_res + WIDTH'($signed(a_i[8*i +: 8])) + WIDTH'($signed(b_i[8*i +: 8]));
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NLANES; gi++) begin : g_lane
            logic [LANE:0] lane_sum;
            assign lane_sum = {a_i[gi*LANE+LANE-1], a_i[gi*LANE +: LANE]}
                            + {b_i[gi*LANE+LANE-1], b_i[gi*LANE +: LANE]};
            // Disagreeing top two bits means the lane overflowed; clamp toward its sign.
            assign padd_res[gi*LANE +: LANE] = (lane_sum[LANE] != lane_sum[LANE-1])
                ? {lane_sum[LANE], {(LANE-1){~lane_sum[LANE]}}}
                : lane_sum[LANE-1:0];
        end
    endgenerate

    always_comb begin
        result_o = a_i;
        ovf_o    = 1'b0;
        case (opcode_i)
            OP_ADD:    begin result_o = sum;  ovf_o = add_ovf; end
            OP_SUB:    begin result_o = diff; ovf_o = sub_ovf; end
            OP_XOR:    result_o = a_i ^ b_i;
            OP_RED:    result_o = red_res;
            OP_SLL:    result_o = sll_res;
            OP_SRA:    result_o = sra_res;
            OP_ROR:    result_o = ror_res;
            OP_PADDSB: result_o = padd_res;
            OP_LW, OP_SW: result_o = lw_res;
            OP_LHB:    result_o = lhb_res;
            OP_LLB, OP_LLB_ALT0, OP_LLB_ALT1: result_o = llb_res;
            default:   result_o = a_i;
        endcase
    end
endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU top: valid/ready handshake, iterative shift-add multiplier,
// and the output/flag registers behind a single-entry result slot.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANE  = DEF_LANE
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_vld_q, out_vld_d;
    logic [2:0]       flag_q, flag_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] core_res;
    logic             core_ovf;
    logic [WIDTH-1:0] mul_sum;
    logic             busy;
    logic             in_rdy;
    logic             accept;

    alu_core #(
        .WIDTH (WIDTH),
        .LANE  (LANE)
    ) u_core (
        .opcode_i (bus.opcode),
        .a_i      (bus.input_A),
        .b_i      (bus.input_B),
        .result_o (core_res),
        .ovf_o    (core_ovf)
    );

    assign busy        = (state_q == MS_RUN);
    assign in_rdy      = !busy && (!out_vld_q || bus.out_rdy);
    assign accept      = bus.in_vld && in_rdy;
    assign mul_sum     = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign bus.in_rdy  = in_rdy;
    assign bus.busy    = busy;
    assign bus.out_vld = out_vld_q;
    assign bus.out     = out_q;
    assign bus.flag    = flag_q;

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        out_vld_d = out_vld_q;
        flag_d    = flag_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;

        if (bus.flush) begin
            // Flush wins over everything, including an accept offered this cycle.
            state_d   = MS_IDLE;
            out_vld_d = 1'b0;
            acc_d     = '0;
            cnt_d     = '0;
        end else begin
            if (out_vld_q && bus.out_rdy) begin
                out_vld_d = 1'b0;
            end
            if (state_q == MS_RUN) begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d        = MS_IDLE;
                    cnt_d          = '0;
                    out_d          = mul_sum;
                    out_vld_d      = 1'b1;
                    flag_d[FLAG_Z] = (mul_sum == '0);
                end
            end else if (accept) begin
                if (bus.opcode == OP_MUL) begin
                    state_d  = MS_RUN;
                    acc_d    = '0;
                    cnt_d    = '0;
                    mcand_d  = bus.input_A;
                    mplier_d = bus.input_B;
                end else begin
                    out_d     = core_res;
                    out_vld_d = 1'b1;
                    if (updates_z(bus.opcode)) begin
                        flag_d[FLAG_Z] = (core_res == '0);
                    end
                    if (updates_nv(bus.opcode)) begin
                        flag_d[FLAG_N] = core_res[WIDTH-1];
                        flag_d[FLAG_V] = core_ovf;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MS_IDLE;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            flag_q    <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            flag_q    <= flag_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a back-to-back vector table plus hand-written
// sequences for MUL timing, output stall, flush and asynchronous reset.
module tb_alu_pipe;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(16)) bus ();

    alu_pipe #(
        .WIDTH (16),
        .LANE  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [2:0]  flg;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", nm, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.opcode  = op;
        bus.input_A = a;
        bus.input_B = b;
        bus.in_vld  = 1'b1;
    endtask

    task automatic add_vec(input string nm, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] res, input logic [2:0] flg);
        vec_t v;
        v.name = nm; v.op = op; v.a = a; v.b = b; v.res = res; v.flg = flg;
        vecs.push_back(v);
    endtask

    task automatic do_mul(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] res, input logic [2:0] flg);
        int busy_cnt = 0;
        int rdy_hi   = 0;
        drive(OP_MUL, a, b);
        tick();
        bus.in_vld = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!bus.busy) break;
            busy_cnt++;
            if (bus.in_rdy || bus.out_vld) rdy_hi++;
            tick();
        end
        chk({nm, " busy cycles"}, busy_cnt, 16);
        chk({nm, " in_rdy/out_vld low while busy"}, rdy_hi, 0);
        chk({nm, " out_vld"}, bus.out_vld, 1);
        chk({nm, " out"}, bus.out, res);
        chk({nm, " flag"}, bus.flag, flg);
        tick();
        chk({nm, " consumed"}, bus.out_vld, 0);
    endtask

    initial begin
        int bad;
        bus.in_vld  = 1'b0;
        bus.opcode  = 4'h0;
        bus.input_A = '0;
        bus.input_B = '0;
        bus.flush   = 1'b0;
        bus.out_rdy = 1'b1;

        // Expected flags follow the running {N,V,Z} state from reset (000).
        add_vec("ADD ovf",      OP_ADD,    16'h7FFF, 16'h0001, 16'h8000, 3'b110);
        add_vec("ADD wrap",     OP_ADD,    16'hFFFF, 16'h0001, 16'h0000, 3'b001);
        add_vec("SUB ovf",      OP_SUB,    16'h8000, 16'h0001, 16'h7FFF, 3'b010);
        add_vec("XOR",          OP_XOR,    16'h00FF, 16'h0F0F, 16'h0FF0, 3'b010);
        add_vec("XOR zero",     OP_XOR,    16'h1234, 16'h1234, 16'h0000, 3'b011);
        add_vec("LW",           OP_LW,     16'h1001, 16'h0010, 16'h1020, 3'b011);
        add_vec("SLL",          OP_SLL,    16'h0001, 16'h0014, 16'h0010, 3'b010);
        add_vec("SRA",          OP_SRA,    16'h8000, 16'h0003, 16'hF000, 3'b010);
        add_vec("ROR 1",        OP_ROR,    16'h0001, 16'h0001, 16'h8000, 3'b010);
        add_vec("ROR 0",        OP_ROR,    16'h1234, 16'h0000, 16'h1234, 3'b010);
        add_vec("RED zero",     OP_RED,    16'h0000, 16'h0000, 16'h0000, 3'b011);
        add_vec("PADDSB sat+",  OP_PADDSB, 16'h7777, 16'h1111, 16'h7777, 3'b010);
        add_vec("PADDSB plain", OP_PADDSB, 16'h1234, 16'h1111, 16'h2345, 3'b010);
        add_vec("PADDSB sat-",  OP_PADDSB, 16'h8888, 16'hFFFF, 16'h8888, 3'b010);
        add_vec("RED pos",      OP_RED,    16'h0102, 16'h0304, 16'h000A, 3'b010);
        add_vec("RED neg",      OP_RED,    16'hFFFF, 16'hFF00, 16'hFFFD, 3'b010);
        add_vec("RED min",      OP_RED,    16'h8080, 16'h8080, 16'hFE00, 3'b010);
        add_vec("SUB zero",     OP_SUB,    16'h0005, 16'h0005, 16'h0000, 3'b001);
        add_vec("LHB",          OP_LHB,    16'h1234, 16'h00AB, 16'hAB34, 3'b001);
        add_vec("LLB",          OP_LLB,    16'h1234, 16'h00AB, 16'h12AB, 3'b001);
        add_vec("op 1100",      4'b1100,   16'h1234, 16'h5566, 16'h1266, 3'b001);
        add_vec("op 1101",      4'b1101,   16'h1234, 16'h5566, 16'h1266, 3'b001);
        add_vec("PCS",          OP_PCS,    16'hBEEF, 16'h0000, 16'hBEEF, 3'b001);
        add_vec("SW",           OP_SW,     16'h0003, 16'h0001, 16'h0004, 3'b001);
        add_vec("SUB neg",      OP_SUB,    16'h0000, 16'h0001, 16'hFFFF, 3'b100);
        add_vec("ADD negovf",   OP_ADD,    16'h8000, 16'h8000, 16'h0000, 3'b011);
        add_vec("SLL 15",       OP_SLL,    16'h0003, 16'h000F, 16'h8000, 3'b010);
        add_vec("SRA pos",      OP_SRA,    16'h7000, 16'h0004, 16'h0700, 3'b010);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset out", bus.out, 16'h0000);
        chk("reset out_vld", bus.out_vld, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset flag", bus.flag, 3'b000);
        rst = 1'b0;
        #1;
        chk("in_rdy after release", bus.in_rdy, 1);

        // Back-to-back table: one operation accepted every cycle
        drive(vecs[0].op, vecs[0].a, vecs[0].b);
        for (int i = 0; i < vecs.size(); i++) begin
            #1;
            chk({vecs[i].name, " in_rdy"}, bus.in_rdy, 1);
            tick();
            chk({vecs[i].name, " out_vld"}, bus.out_vld, 1);
            chk({vecs[i].name, " out"}, bus.out, vecs[i].res);
            chk({vecs[i].name, " flag"}, bus.flag, vecs[i].flg);
            if (i + 1 < vecs.size()) drive(vecs[i+1].op, vecs[i+1].a, vecs[i+1].b);
            else bus.in_vld = 1'b0;
        end
        tick();
        chk("table drained", bus.out_vld, 0);

        // MUL latency and flag behaviour (flag currently 010)
        do_mul("MUL 12*34", 16'h0012, 16'h0034, 16'h03A8, 3'b010);
        do_mul("MUL zero",  16'h0100, 16'h0100, 16'h0000, 3'b011);
        do_mul("MUL ffff",  16'hFFFF, 16'hFFFF, 16'h0001, 3'b010);

        // Output stall holds result and flag, then accept replaces it without a bubble
        drive(OP_SUB, 16'h0005, 16'h0005);
        tick();
        chk("stall SUB out", bus.out, 16'h0000);
        chk("stall SUB flag", bus.flag, 3'b001);
        drive(OP_LLB, 16'h1234, 16'h00AB);
        bus.out_rdy = 1'b0;
        #1;
        chk("stall in_rdy low", bus.in_rdy, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall held out", bus.out, 16'h0000);
            chk("stall held vld", bus.out_vld, 1);
        end
        bus.out_rdy = 1'b1;
        #1;
        chk("stall release in_rdy", bus.in_rdy, 1);
        tick();
        bus.in_vld = 1'b0;
        chk("LLB after stall out", bus.out, 16'h12AB);
        chk("LLB after stall vld", bus.out_vld, 1);
        chk("LLB after stall flag", bus.flag, 3'b001);

        // Flush on cycle 5 of a MUL
        drive(OP_MUL, 16'h0012, 16'h0034);
        tick();
        bus.in_vld = 1'b0;
        repeat (3) tick();
        chk("MUL still busy before flush", bus.busy, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush busy", bus.busy, 0);
        chk("flush out_vld", bus.out_vld, 0);
        chk("flush flag", bus.flag, 3'b001);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.out_vld || bus.busy) bad++;
        end
        chk("no result after flush", bad, 0);
        drive(OP_ADD, 16'h0001, 16'h0001);
        tick();
        bus.in_vld = 1'b0;
        chk("ADD after flush out", bus.out, 16'h0002);
        chk("ADD after flush flag", bus.flag, 3'b000);

        // Flush beats a same-cycle accept
        drive(OP_SUB, 16'h0003, 16'h0003);
        bus.flush = 1'b1;
        tick();
        bus.flush  = 1'b0;
        bus.in_vld = 1'b0;
        chk("flush+accept vld", bus.out_vld, 0);
        chk("flush+accept out", bus.out, 16'h0002);
        chk("flush+accept flag", bus.flag, 3'b000);

        // Flush drops a stalled result
        bus.out_rdy = 1'b0;
        drive(OP_ADD, 16'h0001, 16'h0002);
        tick();
        bus.in_vld = 1'b0;
        chk("stalled ADD vld", bus.out_vld, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush   = 1'b0;
        bus.out_rdy = 1'b1;
        chk("flush stalled vld", bus.out_vld, 0);

        // Asynchronous reset in the middle of a MUL
        drive(OP_ADD, 16'h7FFF, 16'h0001);
        tick();
        chk("pre-reset flag", bus.flag, 3'b110);
        drive(OP_MUL, 16'h0012, 16'h0034);
        tick();
        bus.in_vld = 1'b0;
        repeat (3) tick();
        #3;
        rst = 1'b1;
        #1;
        chk("async rst out", bus.out, 16'h0000);
        chk("async rst out_vld", bus.out_vld, 0);
        chk("async rst busy", bus.busy, 0);
        chk("async rst flag", bus.flag, 3'b000);
        tick();
        rst = 1'b0;
        #1;
        chk("in_rdy after mid-MUL reset", bus.in_rdy, 1);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.out_vld || bus.busy) bad++;
        end
        chk("no stale result after reset", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, 16, datapath width; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter: LANE, 4, sub-word width for PADDSB; SHALL divide WIDTH.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous and active-high.
REQ-005 Port: in_vld  in  1  operation offered.
REQ-006 Port: in_rdy  out  1  block can accept the offered operation.
REQ-007 Port: opcode  in  4  operation select (encodings in REQ-012).
REQ-008 Port: input_A  in  WIDTH  first operand, base address, or rd value.
REQ-009 Port: input_B  in  WIDTH  second operand, shift amount, or immediate.
REQ-010 Port: flush  in  1  discard the in-flight and held operation.
REQ-011 Port: out_vld  out  1, out_rdy  in  1, out  out  WIDTH, flag  out  3 {N,V,Z} registered, busy  out  1 (MUL iterating).

Function
REQ-012 Opcodes SHALL be: ADD 0000, SUB 0001, XOR 0010, RED 0011, SLL 0100, SRA 0101, ROR 0110, PADDSB 0111, LW 1000, SW 1001, LHB 1010, LLB 1011, PCS 1110, MUL 1111; 1100/1101 SHALL behave as LLB.
REQ-013 Accept = in_vld & in_rdy; in_rdy = !busy & (!out_vld | out_rdy).
REQ-014 All opcodes except MUL: result registered into out, out_vld high the cycle after accept (latency 1).
REQ-015 ADD/SUB: A±B modulo 2^WIDTH; V = signed overflow; N = result MSB.
REQ-016 LW/SW: (A & ~1) + (B << 1), no flag update.
REQ-017 SLL/SRA/ROR: shift/rotate A by B[log2(WIDTH)-1:0]; SRA sign-fills; ROR amount 0 returns A.
REQ-018 PADDSB: independent signed saturating add per LANE-bit lane.
REQ-019 RED: sum of all byte lanes of A and B, sign-extended to WIDTH.
REQ-020 LHB: {B[7:0], A[WIDTH-9:0]}; LLB: {A[WIDTH-1:8], B[7:0]}; PCS: A.
REQ-021 MUL: iterative shift-add, low WIDTH bits of A*B; busy high exactly WIDTH cycles from accept; out_vld high WIDTH+1 cycles after accept; in_rdy low while busy.
REQ-022 Flag register SHALL update only on the cycle a result is captured: Z on ADD, SUB, XOR, RED, SLL, SRA, ROR, PADDSB, MUL; V and N on ADD and SUB only; other opcodes leave flag unchanged.
REQ-023 out/out_vld SHALL hold stable while out_vld & !out_rdy.
REQ-024 Back-to-back: with out_rdy held high, one single-cycle op SHALL complete per cycle.
REQ-025 flush SHALL clear out_vld and busy next edge, abort MUL, block flag update, and take priority over a same-cycle accept (operation discarded).
REQ-026 Accept and out_rdy in same cycle SHALL replace the held result without a bubble.

Reset
REQ-027 rst high SHALL force out = 0, out_vld = 0, busy = 0, flag = 000, MUL counter/accumulator = 0, immediately and independent of clk.
REQ-028 Reset mid-MUL SHALL abandon the operation; no result emitted after release.
REQ-029 in_rdy SHALL be 1 the first cycle after reset release.

Structure
REQ-030 Opcode constants, flag bit indices and default WIDTH/LANE SHALL live in shared package alu_pkg.
REQ-031 Combinational single-cycle datapath SHALL be sub-module alu_core; alu_pipe holds handshake, MUL sequencer, output and flag registers.

Verification
REQ-032 ADD A=7FFF B=0001 -> out=8000, flag N=1 V=1 Z=0, one cycle after accept.
REQ-033 MUL A=0012 B=0034 -> busy 16 cycles, in_rdy low meanwhile, out=03A8 on cycle 17, Z=0, V/N unchanged.
REQ-034 SUB A=0005 B=0005 then LLB A=1234 B=00AB with out_rdy=0 two cycles -> out=0000 Z=1 held stable, then 12AB, flag still Z=1.
REQ-035 PADDSB A=7777 B=1111 -> out=7777 (all lanes saturate); ROR A=0001 B=0001 -> 8000.
REQ-036 flush on cycle 5 of MUL -> busy and out_vld low next cycle, flag unchanged, next ADD 0001+0001 -> 0002.
REQ-037 rst asserted mid-MUL -> outputs zero asynchronously; after release in_rdy=1, no stale out_vld.
